osc_adsr_envelope: RTL and testbench
====================================

# osc_adsr_envelope

Amplitude-envelope stage placed directly downstream of the oscillator tops (osc_saw_top, and the square and triangle tops). It consumes the signed oscillator sample and a note gate. An ADSR state machine (attack, decay, sustain, release) generates an unsigned envelope level. The block multiplies each sample by that level and outputs a registered, scaled signed sample to the mixer or DAC stage. Envelope stepping is paced by an external clock-enable pulse, normally from a clock_enable instance, so envelope rates are set independently of the system clock.

## Interface
- WAVE_WIDTH_P, 24, width of the signed oscillator sample in and out
- ENV_WIDTH_P, 16, width of the unsigned envelope level; full scale is 2**ENV_WIDTH_P-1
- clk  input  1  system clock; everything is on the rising edge
- rst  input  1  asynchronous, active-high reset (one clock; asynchronous active-high reset)
- osc_wave  input  WAVE_WIDTH_P signed  oscillator sample
- gate  input  1  note on (1) / off (0), level-sensitive, synchronous to clk
- env_enable  input  1  single-cycle pulse; envelope level steps only on cycles where it is high
- cr_attack_inc  input  ENV_WIDTH_P  level increment per env_enable in ATTACK
- cr_decay_inc  input  ENV_WIDTH_P  level decrement per env_enable in DECAY
- cr_sustain_level  input  ENV_WIDTH_P  sustain level
- cr_release_inc  input  ENV_WIDTH_P  level decrement per env_enable in RELEASE
- osc_env_wave  output  WAVE_WIDTH_P signed  enveloped sample
- env_level  output  ENV_WIDTH_P  current envelope level
- env_state  output  3  current state, encoded as env_state_t

## Operation
- States: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE. Names the max level MAX = 2**ENV_WIDTH_P-1.
- Transitions are evaluated every clk. Level arithmetic applies only when env_enable=1. The exception is SUSTAIN, which loads the level on every clk.

**Gate-driven transitions (highest priority; the level is held on that edge):**
- gate=1 in IDLE or RELEASE: go to ATTACK. Attack starts from the current level, so a retrigger during release does not restart from 0.
- gate=0 in ATTACK, DECAY or SUSTAIN: go to RELEASE.

**Level update per state (gate unchanged):**
- ATTACK: if level+cr_attack_inc >= MAX, load MAX and go to DECAY. Otherwise add cr_attack_inc.
- DECAY: if level-cr_decay_inc <= cr_sustain_level, load cr_sustain_level and go to SUSTAIN. Otherwise subtract cr_decay_inc.
- SUSTAIN: load cr_sustain_level every clk, so it tracks live changes.
- RELEASE: if level <= cr_release_inc, load 0 and go to IDLE. Otherwise subtract cr_release_inc.
- IDLE: level stays 0.

**Arithmetic and edge rules:**
- All add/subtract is done in ENV_WIDTH_P+1 bits, so the level can never wrap.
- An increment of 0 holds the current state indefinitely. This is legal and must not be flagged.
- cr_sustain_level above MAX is impossible by width. A sustain level equal to MAX makes DECAY exit on its first step.

**Sample scaling (VCA):**
- product = osc_wave * $signed({1'b0, env_level}), held at WAVE_WIDTH_P+ENV_WIDTH_P+1 bits.
- osc_env_wave = product >>> ENV_WIDTH_P, arithmetic shift, truncated toward minus infinity; no rounding.
- The result always fits WAVE_WIDTH_P bits, so no saturation is needed.

## Timing
- Reset values: env_state=IDLE, env_level=0, osc_env_wave=0. Reset asserted mid-note returns to IDLE immediately, regardless of gate.
- env_state and env_level are registered and update on the same edge.
- osc_env_wave is registered: one cycle of latency from osc_wave and from env_level. The sample at edge n uses the env_level value present before edge n.
- gate to env_state response is one edge.
- No handshake: every clk produces a valid output sample.

## Structure
- Package osc_env_pkg holds:
  - typedef enum logic [2:0] env_state_t, encoded IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4;
  - ENV_STATE_WIDTH_C = 3.
- Sub-module osc_env_vca: the registered signed×unsigned multiply and shift, parameterised on WAVE_WIDTH_P and ENV_WIDTH_P.
- The FSM and level register live in osc_adsr_envelope.

## Test plan
- **Reset:** rst pulsed mid-ATTACK with gate=1 → outputs 0 and state IDLE during reset. After release, ATTACK begins one edge later, from level 0.
- **Attack/decay:** ENV_WIDTH_P=16, env_enable always 1, attack_inc=0x4000, decay_inc=0x1000, sustain=0x8000, gate=1.
  - Levels: 0x4000, 0x8000, 0xC000, 0xFFFF (state DECAY).
  - Then 0xEFFF … down to 0x8000 (state SUSTAIN) on the 8th decay step.
- **Release and retrigger:** in SUSTAIN at 0x8000, release_inc=0x3000, gate→0.
  - Next edge: RELEASE, level still 0x8000. Then 0x5000, 0x2000, then 0 (IDLE).
  - Variant: gate→1 while level is 0x5000 → ATTACK continues from 0x5000.
- **VCA extremes:** level 0xFFFF with osc_wave=8388607 → 8388479; with osc_wave=-8388608 → -8388480. Level 0 → 0. Each appears one cycle after the input.
- **Pacing:** env_enable pulsed every 4th cycle → level changes only on pulse edges, while gate transitions still occur on any edge.
- **Live sustain and zero increment:** cr_sustain_level changed during SUSTAIN → env_level follows within one edge. attack_inc=0 → level stays constant in ATTACK for 1000 cycles.

Source files
------------

// File: rtl/osc_env_pkg.sv
// Shared types for the oscillator amplitude-envelope stage.
// env_state_t is the ADSR state encoding that is visible on the env_state port.
package osc_env_pkg;
  localparam int ENV_STATE_WIDTH_C = 3;

  typedef enum logic [ENV_STATE_WIDTH_C-1:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } env_state_t;
endpackage

// File: rtl/osc_env_vca.sv
// Registered VCA: multiplies the signed sample by the unsigned envelope level,
// then arithmetic-shifts the product right by ENV_WIDTH_P. The shift floors
// toward minus infinity and does not round.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   i_wave          signed sample in
//   i_level         unsigned envelope level (full scale 2**ENV_WIDTH_P-1)
//   o_wave          registered scaled sample, one cycle of latency
module osc_env_vca #(
  parameter int WAVE_WIDTH_P = 24,
  parameter int ENV_WIDTH_P  = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic signed [WAVE_WIDTH_P-1:0] i_wave,
  input  logic        [ENV_WIDTH_P-1:0]  i_level,
  output logic signed [WAVE_WIDTH_P-1:0] o_wave
);
  localparam int PW_C = WAVE_WIDTH_P + ENV_WIDTH_P + 1;

  logic signed [PW_C-1:0] w_wave_x;
  logic signed [PW_C-1:0] w_level_x;
  logic signed [PW_C-1:0] w_prod;
  logic signed [WAVE_WIDTH_P-1:0] r_wave;

  // Sign-extend the sample and zero-extend the level so the multiply is
  // signed x unsigned. The full product always fits in PW_C bits.
  assign w_wave_x  = {{(ENV_WIDTH_P+1){i_wave[WAVE_WIDTH_P-1]}}, i_wave};
  assign w_level_x = {{(WAVE_WIDTH_P+1){1'b0}}, i_level};
  assign w_prod    = w_wave_x * w_level_x;

  // |level| < 2**ENV_WIDTH_P, so the shifted product always fits
  // WAVE_WIDTH_P bits and needs no saturation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_wave <= '0;
    else     r_wave <= WAVE_WIDTH_P'(w_prod >>> ENV_WIDTH_P);
  end

  assign o_wave = r_wave;
endmodule

// File: rtl/osc_adsr_envelope.sv
// ADSR amplitude envelope placed after the oscillator tops. The gate drives
// state changes on any clk edge. Level stepping happens only on env_enable
// pulses, except in SUSTAIN, which tracks cr_sustain_level on every clk.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   osc_wave            signed oscillator sample
//   gate                note on/off, level-sensitive
//   env_enable          envelope step pulse
//   cr_attack_inc       level increment per step in ATTACK
//   cr_decay_inc        level decrement per step in DECAY
//   cr_sustain_level    sustain level
//   cr_release_inc      level decrement per step in RELEASE
//   osc_env_wave        registered enveloped sample
//   env_level           current envelope level
//   env_state           current ADSR state
module osc_adsr_envelope
  import osc_env_pkg::*;
#(
  parameter int WAVE_WIDTH_P = 24,
  parameter int ENV_WIDTH_P  = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic signed [WAVE_WIDTH_P-1:0] osc_wave,
  input  logic                           gate,
  input  logic                           env_enable,
  input  logic        [ENV_WIDTH_P-1:0]  cr_attack_inc,
  input  logic        [ENV_WIDTH_P-1:0]  cr_decay_inc,
  input  logic        [ENV_WIDTH_P-1:0]  cr_sustain_level,
  input  logic        [ENV_WIDTH_P-1:0]  cr_release_inc,
  output logic signed [WAVE_WIDTH_P-1:0] osc_env_wave,
  output logic        [ENV_WIDTH_P-1:0]  env_level,
  output env_state_t                     env_state
);
  localparam logic [ENV_WIDTH_P:0] MAX_C = {1'b0, {ENV_WIDTH_P{1'b1}}};

  env_state_t             r_state, w_state_nxt;
  logic [ENV_WIDTH_P-1:0] r_level, w_level_nxt;

  // Arithmetic uses one extra bit, so a sum that overflows or a difference
  // that underflows is visible as a carry or borrow and never wraps.
  logic [ENV_WIDTH_P:0] w_att_sum, w_dec_diff, w_rel_diff;
  logic                 w_att_hit, w_dec_hit, w_rel_hit;

  assign w_att_sum  = {1'b0, r_level} + {1'b0, cr_attack_inc};
  assign w_dec_diff = {1'b0, r_level} - {1'b0, cr_decay_inc};
  assign w_rel_diff = {1'b0, r_level} - {1'b0, cr_release_inc};

  assign w_att_hit = (w_att_sum >= MAX_C);
  assign w_dec_hit = w_dec_diff[ENV_WIDTH_P] ||
                     (w_dec_diff[ENV_WIDTH_P-1:0] <= cr_sustain_level);
  // level <= inc: either a borrow or an exact zero
  assign w_rel_hit = w_rel_diff[ENV_WIDTH_P] ||
                     (w_rel_diff[ENV_WIDTH_P-1:0] == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_level <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_level <= w_level_nxt;
    end
  end

  // The gate has priority. On a gate-driven transition the level is held,
  // so a retrigger during release continues from the current level.
  always_comb begin
    w_state_nxt = r_state;
    w_level_nxt = r_level;
    case (r_state)
      IDLE: begin
        w_level_nxt = '0;
        if (gate) w_state_nxt = ATTACK;
      end
      ATTACK: begin
        if (!gate) w_state_nxt = RELEASE;
        else if (env_enable) begin
          if (w_att_hit) begin
            w_level_nxt = MAX_C[ENV_WIDTH_P-1:0];
            w_state_nxt = DECAY;
          end else begin
            w_level_nxt = w_att_sum[ENV_WIDTH_P-1:0];
          end
        end
      end
      DECAY: begin
        if (!gate) w_state_nxt = RELEASE;
        else if (env_enable) begin
          if (w_dec_hit) begin
            w_level_nxt = cr_sustain_level;
            w_state_nxt = SUSTAIN;
          end else begin
            w_level_nxt = w_dec_diff[ENV_WIDTH_P-1:0];
          end
        end
      end
      SUSTAIN: begin
        if (!gate) w_state_nxt = RELEASE;
        else       w_level_nxt = cr_sustain_level;
      end
      RELEASE: begin
        if (gate) w_state_nxt = ATTACK;
        else if (env_enable) begin
          if (w_rel_hit) begin
            w_level_nxt = '0;
            w_state_nxt = IDLE;
          end else begin
            w_level_nxt = w_rel_diff[ENV_WIDTH_P-1:0];
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_level_nxt = '0;
      end
    endcase
  end

  // The VCA sees the pre-edge level, so each output sample pairs with the
  // envelope level that was on env_level when the sample was taken.
  osc_env_vca #(
    .WAVE_WIDTH_P(WAVE_WIDTH_P),
    .ENV_WIDTH_P (ENV_WIDTH_P)
  ) u_vca (
    .clk    (clk),
    .rst    (rst),
    .i_wave (osc_wave),
    .i_level(r_level),
    .o_wave (osc_env_wave)
  );

  assign env_level = r_level;
  assign env_state = r_state;
endmodule

// File: tb/tb_osc_adsr_envelope.sv
// Scoreboard bench for osc_adsr_envelope. The driver applies one vector per
// cycle on the falling edge and queues the hand-computed outputs expected
// after the next rising edge. The monitor pops and compares after each
// rising edge.
module tb_osc_adsr_envelope;
  import osc_env_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [23:0] osc_wave;
  logic               gate;
  logic               env_enable;
  logic        [15:0] cr_attack_inc, cr_decay_inc, cr_sustain_level, cr_release_inc;
  logic signed [23:0] osc_env_wave;
  logic        [15:0] env_level;
  env_state_t         env_state;

  osc_adsr_envelope #(.WAVE_WIDTH_P(24), .ENV_WIDTH_P(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .osc_wave        (osc_wave),
    .gate            (gate),
    .env_enable      (env_enable),
    .cr_attack_inc   (cr_attack_inc),
    .cr_decay_inc    (cr_decay_inc),
    .cr_sustain_level(cr_sustain_level),
    .cr_release_inc  (cr_release_inc),
    .osc_env_wave    (osc_env_wave),
    .env_level       (env_level),
    .env_state       (env_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                 id;
    env_state_t         s;
    logic        [15:0] l;
    logic signed [23:0] w;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_id = 0;

  task automatic chk(input string nm, input int id, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s (vector %0d): got %0d (0x%0h), want %0d (0x%0h)",
               nm, id, act, act, exp, exp);
    end
  endtask

  // Drive one cycle of inputs (the current time is a falling edge), queue the
  // outputs expected after the next rising edge, then move to the next
  // falling edge.
  task automatic step(input logic r, input logic g, input logic e,
                      input logic signed [23:0] w,
                      input env_state_t s, input logic [15:0] l,
                      input logic signed [23:0] ow);
    exp_t x;
    rst = r; gate = g; env_enable = e; osc_wave = w;
    x.id = vec_id; x.s = s; x.l = l; x.w = ow;
    q.push_back(x);
    vec_id++;
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    exp_t x;
    #1;
    if (q.size() > 0) begin
      x = q.pop_front();
      chk("env_state",    x.id, int'(env_state),    int'(x.s));
      chk("env_level",    x.id, int'(env_level),    int'(x.l));
      chk("osc_env_wave", x.id, int'(osc_env_wave), int'(x.w));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] lv;
    rst = 1'b1; gate = 1'b0; env_enable = 1'b0; osc_wave = '0;
    cr_attack_inc = 16'h4000; cr_decay_inc = 16'h1000;
    cr_sustain_level = 16'h8000; cr_release_inc = 16'h3000;
    @(negedge clk);
    chk("reset_state", -1, int'(env_state), int'(IDLE));
    chk("reset_level", -1, int'(env_level), 0);
    chk("reset_wave",  -1, int'(osc_env_wave), 0);

    // Reset pulsed mid-attack
    step(1, 0, 0, 0, IDLE, 16'h0, 0);
    step(0, 1, 1, 0, ATTACK, 16'h0, 0);
    step(0, 1, 1, 0, ATTACK, 16'h4000, 0);
    rst = 1'b1;
    #1;
    chk("async_rst_state", -2, int'(env_state), int'(IDLE));
    chk("async_rst_level", -2, int'(env_level), 0);
    step(1, 1, 1, 0, IDLE, 16'h0, 0);
    step(0, 1, 1, 0, ATTACK, 16'h0, 0);

    // Attack and decay into sustain
    step(0, 1, 1, 0, ATTACK, 16'h4000, 0);
    step(0, 1, 1, 0, ATTACK, 16'h8000, 0);
    step(0, 1, 1, 0, ATTACK, 16'hC000, 0);
    step(0, 1, 1, 0, DECAY,  16'hFFFF, 0);
    for (int i = 1; i <= 7; i++) begin
      lv = 16'hFFFF - 16'(i * 16'h1000);
      step(0, 1, 1, 0, DECAY, lv, 0);
    end
    step(0, 1, 1, 0, SUSTAIN, 16'h8000, 0);
    step(0, 1, 1, 0, SUSTAIN, 16'h8000, 0);

    // Live sustain tracking
    cr_sustain_level = 16'h7000;
    step(0, 1, 0, 0, SUSTAIN, 16'h7000, 0);
    cr_sustain_level = 16'h8000;
    step(0, 1, 0, 0, SUSTAIN, 16'h8000, 0);

    // Release to idle
    step(0, 0, 1, 0, RELEASE, 16'h8000, 0);
    step(0, 0, 1, 0, RELEASE, 16'h5000, 0);
    step(0, 0, 1, 0, RELEASE, 16'h2000, 0);
    step(0, 0, 1, 0, IDLE,    16'h0,    0);
    step(0, 0, 1, 0, IDLE,    16'h0,    0);

    // Retrigger during release continues from the current level
    cr_decay_inc = 16'h8000;
    step(0, 1, 1, 0, ATTACK,  16'h0,    0);
    step(0, 1, 1, 0, ATTACK,  16'h4000, 0);
    step(0, 1, 1, 0, ATTACK,  16'h8000, 0);
    step(0, 1, 1, 0, ATTACK,  16'hC000, 0);
    step(0, 1, 1, 0, DECAY,   16'hFFFF, 0);
    step(0, 1, 1, 0, SUSTAIN, 16'h8000, 0);
    step(0, 0, 1, 0, RELEASE, 16'h8000, 0);
    step(0, 0, 1, 0, RELEASE, 16'h5000, 0);
    step(0, 1, 1, 0, ATTACK,  16'h5000, 0);
    step(0, 1, 1, 0, ATTACK,  16'h9000, 0);
    step(0, 1, 1, 0, ATTACK,  16'hD000, 0);
    step(0, 1, 1, 0, DECAY,   16'hFFFF, 0);
    step(0, 1, 1, 0, SUSTAIN, 16'h8000, 0);

    // VCA extremes at full-scale level, then at level 0
    cr_sustain_level = 16'hFFFF;
    step(0, 1, 1, 0,         SUSTAIN, 16'hFFFF, 0);
    step(0, 1, 1, 8388607,   SUSTAIN, 16'hFFFF, 8388479);
    step(0, 1, 1, -8388608,  SUSTAIN, 16'hFFFF, -8388480);
    cr_release_inc = 16'hFFFF;
    step(0, 0, 1, 0,         RELEASE, 16'hFFFF, 0);
    step(0, 0, 1, 0,         IDLE,    16'h0,    0);
    step(0, 0, 1, 8388607,   IDLE,    16'h0,    0);
    step(0, 0, 1, -8388608,  IDLE,    16'h0,    0);

    // Pacing: steps only on env_enable, gate acts on any edge
    cr_release_inc = 16'h3000; cr_decay_inc = 16'h1000; cr_sustain_level = 16'h8000;
    step(0, 1, 0, 0, ATTACK,  16'h0,    0);
    step(0, 1, 0, 0, ATTACK,  16'h0,    0);
    step(0, 1, 0, 0, ATTACK,  16'h0,    0);
    step(0, 1, 1, 0, ATTACK,  16'h4000, 0);
    step(0, 1, 0, 0, ATTACK,  16'h4000, 0);
    step(0, 1, 0, 0, ATTACK,  16'h4000, 0);
    step(0, 1, 0, 0, ATTACK,  16'h4000, 0);
    step(0, 1, 1, 0, ATTACK,  16'h8000, 0);
    step(0, 0, 0, 0, RELEASE, 16'h8000, 0);
    step(0, 0, 0, 0, RELEASE, 16'h8000, 0);
    step(0, 0, 1, 0, RELEASE, 16'h5000, 0);
    step(0, 0, 0, 0, RELEASE, 16'h5000, 0);
    step(0, 1, 0, 0, ATTACK,  16'h5000, 0);
    step(0, 0, 0, 0, RELEASE, 16'h5000, 0);
    step(0, 0, 1, 0, RELEASE, 16'h2000, 0);
    step(0, 0, 1, 0, IDLE,    16'h0,    0);

    // Zero attack increment holds ATTACK indefinitely
    step(0, 1, 1, 0, ATTACK, 16'h0,    0);
    step(0, 1, 1, 0, ATTACK, 16'h4000, 0);
    cr_attack_inc = 16'h0;
    for (int i = 0; i < 1000; i++) step(0, 1, 1, 0, ATTACK, 16'h4000, 0);
    step(0, 0, 1, 0, RELEASE, 16'h4000, 0);

    @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) chk("scoreboard_drain", -3, q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
